log_capture_ctrl: RTL and testbench

Sequences sample capture into the on-chip log memory and serves address-driven readback to the register file.
- On a one-cycle run command from the register file, it clears the write pointer and fills the memory with decimated datapath samples until full.
- It then flags full and holds the contents for processor readout.
- It owns the dual-port log RAM and arbitrates the capture write port against the readback port.

---
 rtl/log_capture_ctrl_pkg.sv | 16 +
 rtl/log_capture_ctrl_log_ram.sv | 38 +++
 rtl/log_capture_ctrl.sv | 104 ++++++++++
 tb/tb_log_capture_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/log_capture_ctrl_pkg.sv
// log_capture_ctrl_pkg: shared definitions for the log capture controller and its RAM.
// Holds the capture FSM state encoding and the register-file command codes
// so the controller and the register file decode the same values.
package log_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    localparam logic [7:0] CMD_RUN_MEM     = 8'h01;
    localparam logic [7:0] CMD_READ_MEM    = 8'h02;
    localparam logic [7:0] CMD_IS_MEM_FULL = 8'h03;

endpackage

// File: rtl/log_capture_ctrl_log_ram.sv
// log_ram: simple dual-port log memory, one write port and one registered read-first read port.
// Ports:
//   clk                  clock
//   i_rst                synchronous active-high reset (clears the read data register only)
//   i_we/i_wr_addr/i_wr_data   write port
//   i_rd_en/i_rd_addr    read request; data appears on o_rd_data one cycle later
//   o_rd_data            registered read data, holds when i_rd_en is low
module log_ram #(
    parameter int NB_ADD_MEM = 14,
    parameter int NB_DATA    = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [NB_ADD_MEM-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]    i_wr_data,
    input  logic                  i_rd_en,
    input  logic [NB_ADD_MEM-1:0] i_rd_addr,
    output logic [NB_DATA-1:0]    o_rd_data
);

    logic [NB_DATA-1:0] mem [2**NB_ADD_MEM];
    logic [NB_DATA-1:0] rd_data_q;

    // Contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) mem[i_wr_addr] <= i_wr_data;
    end

    // Non-blocking update makes a same-address read return the old word.
    always_ff @(posedge clk) begin
        if (i_rst) rd_data_q <= '0;
        else if (i_rd_en) rd_data_q <= mem[i_rd_addr];
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/log_capture_ctrl.sv
// log_capture_ctrl: sequences decimated sample capture into the log RAM and serves readback.
// Ports:
//   clk, i_rst           clock, synchronous active-high reset
//   i_run, i_stop        one-cycle start / abort pulses (run wins when both are high)
//   i_decim              keep 1 of every i_decim+1 valid samples, latched at i_run
//   i_data, i_valid      datapath sample and qualifier
//   i_rd_en, i_rd_addr   readback request
//   o_rd_data, o_rd_valid  readback data one cycle after i_rd_en
//   o_mem_full           last capture filled the memory
//   o_busy               capture in progress
//   o_wr_count           words written by the current/last capture
module log_capture_ctrl
    import log_capture_ctrl_pkg::*;
#(
    parameter int NB_ADD_MEM = 14,
    parameter int NB_DATA    = 32,
    parameter int NB_DECIM   = 8
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_run,
    input  logic                  i_stop,
    input  logic [NB_DECIM-1:0]   i_decim,
    input  logic [NB_DATA-1:0]    i_data,
    input  logic                  i_valid,
    input  logic                  i_rd_en,
    input  logic [NB_ADD_MEM-1:0] i_rd_addr,
    output logic [NB_DATA-1:0]    o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_mem_full,
    output logic                  o_busy,
    output logic [NB_ADD_MEM:0]   o_wr_count
);

    state_e                state_q;
    logic [NB_ADD_MEM-1:0] ptr_q;
    logic [NB_ADD_MEM:0]   wr_count_q;
    logic [NB_DECIM-1:0]   dec_cnt_q;
    logic [NB_DECIM-1:0]   decim_q;
    logic                  mem_full_q;
    logic                  rd_valid_q;
    logic                  take;
    logic                  wr_en;

    // A valid sample in CAPTURE that is not pre-empted by run or stop.
    assign take  = !i_rst && !i_run && !i_stop && state_q == ST_CAPTURE && i_valid;
    // The decimator counts down so the first valid sample after i_run is kept.
    assign wr_en = take && dec_cnt_q == '0;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            wr_count_q <= '0;
            dec_cnt_q  <= '0;
            decim_q    <= '0;
            mem_full_q <= 1'b0;
        end else if (i_run) begin
            state_q    <= ST_CAPTURE;
            ptr_q      <= '0;
            wr_count_q <= '0;
            dec_cnt_q  <= '0;
            decim_q    <= i_decim;
            mem_full_q <= 1'b0;
        end else if (state_q == ST_CAPTURE && i_stop) begin
            state_q <= ST_IDLE;
        end else if (wr_en) begin
            ptr_q      <= ptr_q + NB_ADD_MEM'(1);
            wr_count_q <= wr_count_q + (NB_ADD_MEM+1)'(1);
            dec_cnt_q  <= decim_q;
            if (ptr_q == '1) begin
                state_q    <= ST_FULL;
                mem_full_q <= 1'b1;
            end
        end else if (take) begin
            dec_cnt_q <= dec_cnt_q - NB_DECIM'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) rd_valid_q <= 1'b0;
        else rd_valid_q <= i_rd_en;
    end

    log_ram #(
        .NB_ADD_MEM (NB_ADD_MEM),
        .NB_DATA    (NB_DATA)
    ) u_log_ram (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_we      (wr_en),
        .i_wr_addr (ptr_q),
        .i_wr_data (i_data),
        .i_rd_en   (i_rd_en),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

    assign o_rd_valid = rd_valid_q;
    assign o_mem_full = mem_full_q;
    assign o_busy     = state_q == ST_CAPTURE;
    assign o_wr_count = wr_count_q;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// tb_log_capture_ctrl: directed self-checking bench for log_capture_ctrl with a 16-word log.
module tb_log_capture_ctrl;

    localparam int NB_ADD_MEM = 4;
    localparam int NB_DATA    = 32;
    localparam int NB_DECIM   = 8;

    logic                  clk;
    logic                  i_rst;
    logic                  i_run;
    logic                  i_stop;
    logic [NB_DECIM-1:0]   i_decim;
    logic [NB_DATA-1:0]    i_data;
    logic                  i_valid;
    logic                  i_rd_en;
    logic [NB_ADD_MEM-1:0] i_rd_addr;
    logic [NB_DATA-1:0]    o_rd_data;
    logic                  o_rd_valid;
    logic                  o_mem_full;
    logic                  o_busy;
    logic [NB_ADD_MEM:0]   o_wr_count;

    int errors = 0;
    int checks = 0;

    log_capture_ctrl #(
        .NB_ADD_MEM (NB_ADD_MEM),
        .NB_DATA    (NB_DATA),
        .NB_DECIM   (NB_DECIM)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_run      (i_run),
        .i_stop     (i_stop),
        .i_decim    (i_decim),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_rd_en    (i_rd_en),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_mem_full (o_mem_full),
        .o_busy     (o_busy),
        .o_wr_count (o_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cap(input logic [NB_DECIM-1:0] d);
        i_run   = 1'b1;
        i_decim = d;
        tick();
        i_run = 1'b0;
    endtask

    task automatic smp(input logic [31:0] d);
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [NB_ADD_MEM-1:0] a, input logic [31:0] exp);
        i_rd_en   = 1'b1;
        i_rd_addr = a;
        tick();
        i_rd_en = 1'b0;
        chk({tag, "_vld"}, 32'(o_rd_valid), 32'd1);
        chk(tag, o_rd_data, exp);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_full"}, 32'(o_mem_full), 32'd0);
        chk({tag, "_cnt"}, 32'(o_wr_count), 32'd0);
        chk({tag, "_rdv"}, 32'(o_rd_valid), 32'd0);
        chk({tag, "_rdd"}, o_rd_data, 32'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_run = 1'b0; i_stop = 1'b0; i_decim = '0;
        i_data = '0; i_valid = 1'b0; i_rd_en = 1'b0; i_rd_addr = '0;
        tick();
        tick();
        i_rst = 1'b0;
        chk_reset_state("rst");

        // 1. fill with decim 0; four extra samples must be dropped
        run_cap(8'd0);
        chk("t1_busy_start", 32'(o_busy), 32'd1);
        chk("t1_cnt_start", 32'(o_wr_count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            smp(32'h100 + 32'(i));
            chk($sformatf("t1_cnt_%0d", i), 32'(o_wr_count), (i < 16) ? 32'(i + 1) : 32'd16);
            chk($sformatf("t1_full_%0d", i), 32'(o_mem_full), 32'(i >= 15));
            chk($sformatf("t1_busy_%0d", i), 32'(o_busy), 32'(i < 15));
        end
        for (int a = 0; a < 16; a++) rd($sformatf("t1_rd_%0d", a), 4'(a), 32'h100 + 32'(a));
        tick();
        chk("t1_rdv_idle", 32'(o_rd_valid), 32'd0);
        chk("t1_rdd_hold", o_rd_data, 32'h10F);

        // 2. decimation by 3
        run_cap(8'd2);
        for (int i = 0; i < 48; i++) begin
            smp(32'(i));
            chk($sformatf("t2_cnt_%0d", i), 32'(o_wr_count), (i / 3 + 1 > 16) ? 32'd16 : 32'(i / 3 + 1));
            chk($sformatf("t2_full_%0d", i), 32'(o_mem_full), 32'(i >= 45));
        end
        for (int k = 0; k < 16; k++) rd($sformatf("t2_rd_%0d", k), 4'(k), 32'(3 * k));

        // 3. abort after 5 words; the sample on the stop cycle is discarded
        run_cap(8'd0);
        for (int i = 0; i < 5; i++) smp(32'h200 + 32'(i));
        i_stop = 1'b1;
        smp(32'h2FF);
        i_stop = 1'b0;
        chk("t3_busy", 32'(o_busy), 32'd0);
        chk("t3_full", 32'(o_mem_full), 32'd0);
        chk("t3_cnt", 32'(o_wr_count), 32'd5);
        for (int i = 0; i < 3; i++) smp(32'h300 + 32'(i));
        chk("t3_cnt_after", 32'(o_wr_count), 32'd5);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("t3_stop_idle", 32'(o_wr_count), 32'd5);
        rd("t3_rd0", 4'd0, 32'h200);
        rd("t3_rd4", 4'd4, 32'h204);
        rd("t3_rd5", 4'd5, 32'd15);

        // 4. re-run from FULL; sample on the run cycle is not stored
        run_cap(8'd0);
        for (int i = 0; i < 16; i++) smp(32'h400 + 32'(i));
        chk("t4_full", 32'(o_mem_full), 32'd1);
        i_valid = 1'b1;
        i_data  = 32'hDEAD;
        run_cap(8'd0);
        i_valid = 1'b0;
        chk("t4_full_clr", 32'(o_mem_full), 32'd0);
        chk("t4_cnt_clr", 32'(o_wr_count), 32'd0);
        chk("t4_busy", 32'(o_busy), 32'd1);
        smp(32'h500);
        chk("t4_cnt1", 32'(o_wr_count), 32'd1);
        rd("t4_rd0", 4'd0, 32'h500);
        rd("t4_rd1", 4'd1, 32'h401);

        // 5. read-first collision at address 3
        run_cap(8'd0);
        for (int i = 0; i < 4; i++) smp(32'h1111);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        run_cap(8'd0);
        for (int i = 0; i < 3; i++) smp(32'h2222);
        i_rd_en   = 1'b1;
        i_rd_addr = 4'd3;
        smp(32'hABCD);
        i_rd_en = 1'b0;
        chk("t5_coll_vld", 32'(o_rd_valid), 32'd1);
        chk("t5_coll_old", o_rd_data, 32'h1111);
        chk("t5_cnt", 32'(o_wr_count), 32'd4);
        rd("t5_reread", 4'd3, 32'hABCD);

        // 6. reset mid-capture
        run_cap(8'd0);
        for (int i = 0; i < 7; i++) smp(32'h600 + 32'(i));
        chk("t6_cnt7", 32'(o_wr_count), 32'd7);
        i_rst     = 1'b1;
        i_rd_en   = 1'b1;
        i_rd_addr = 4'd0;
        smp(32'hBAD);
        i_rst   = 1'b0;
        i_rd_en = 1'b0;
        chk_reset_state("t6_rst");
        rd("t6_rd7", 4'd7, 32'h407);
        run_cap(8'd0);
        smp(32'h700);
        chk("t6_cnt1", 32'(o_wr_count), 32'd1);
        rd("t6_rd0", 4'd0, 32'h700);
        rd("t6_rd6", 4'd6, 32'h606);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
